// File: rtl/jt8255_periph.sv
// jt8255_periph
// Peripheral-side handshake engine for jt8255 port A in mode 2 (mode 1 is a
// subset). Two independent FSMs share the port A/C pins:
//   TX: presents a byte on port A, strobes STB, then holds the byte until the
//       CPU has read it (IBF high then low). The PPI samples port A live on a
//       CPU read, so the hold time belongs to this block.
//   RX: watches OBF, pulses ACK and pushes the PPI's port A output into a
//       4-entry first-word-fall-through receive FIFO.
// Ports:
//   rst, clk            asynchronous active-high reset, system clock
//   pa_in  / pc_in      PPI porta_dout / portc_dout (pc_in[7]=OBF_n, pc_in[5]=IBF)
//   pa_out / pc_out     PPI porta_din / portc_din (pc_out[6]=ACK, pc_out[4]=STB)
//   pc_aux              pass-through value for the other port C bits
//   tx_data/valid/ready byte stream towards the CPU
//   rx_data/valid/ready byte stream from the CPU (FIFO head, pop on ready)
//   busy                either FSM outside its idle state
module jt8255_periph #(
    parameter int STB_W = 2,
    parameter int ACK_W = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic [7:0] pa_in,
    input  logic [7:0] pc_in,
    output logic [7:0] pa_out,
    output logic [7:0] pc_out,
    input  logic [7:0] pc_aux,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);
    typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_STB, TX_FULL, TX_DRAIN} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_SETTLE, RX_ACK, RX_WAIT} rx_state_t;

    logic obf_n;
    logic ibf;
    assign obf_n = pc_in[7];
    assign ibf   = pc_in[5];

    tx_state_t  tx_state_reg, tx_state_next;
    rx_state_t  rx_state_reg, rx_state_next;
    logic [7:0] stb_cnt_reg, stb_cnt_next;
    logic [7:0] ack_cnt_reg, ack_cnt_next;
    logic [7:0] pa_out_reg;
    logic       stb_reg, ack_reg, tx_ready_reg, busy_reg;
    logic       tx_load, rx_push, rx_pop;

    // Receive FIFO storage and pointers
    logic [7:0] mem [0:3];
    logic [1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [2:0] count_reg, count_next;
    logic [7:0] rx_data_reg, head_next;
    logic       rx_valid_reg;
    logic       fifo_full;

    assign fifo_full = (count_reg == 3'd4);
    assign rx_pop    = rx_ready && rx_valid_reg;

    // TX next-state logic. Acceptance requires the registered tx_ready so a
    // byte is only taken in a cycle where tx_ready was actually shown.
    always_comb begin
        tx_state_next = tx_state_reg;
        stb_cnt_next  = stb_cnt_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_valid && tx_ready_reg) begin
                    tx_load       = 1'b1;
                    tx_state_next = TX_SETUP;
                end
            end
            TX_SETUP: begin
                tx_state_next = TX_STB;
                stb_cnt_next  = 8'd0;
            end
            TX_STB: begin
                if (stb_cnt_reg == 8'(STB_W - 1)) tx_state_next = TX_FULL;
                else                               stb_cnt_next  = stb_cnt_reg + 8'd1;
            end
            // Wait for IBF to rise first so a stale IBF=0 is not taken as the read
            TX_FULL:  if (ibf)  tx_state_next = TX_DRAIN;
            TX_DRAIN: if (!ibf) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // RX next-state logic. A full FIFO leaves OBF low, which is the backpressure.
    always_comb begin
        rx_state_next = rx_state_reg;
        ack_cnt_next  = ack_cnt_reg;
        rx_push       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: if (!obf_n && !fifo_full) rx_state_next = RX_SETTLE;
            // PPI updates porta_dout one cycle after OBF falls
            RX_SETTLE: begin
                rx_state_next = RX_ACK;
                rx_push       = 1'b1;
                ack_cnt_next  = 8'd0;
            end
            RX_ACK: begin
                if (ack_cnt_reg == 8'(ACK_W - 1)) rx_state_next = RX_WAIT;
                else                               ack_cnt_next  = ack_cnt_reg + 8'd1;
            end
            // Waiting for OBF to return high guarantees one push per CPU write
            RX_WAIT: if (obf_n) rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // FIFO bookkeeping. The head register is refreshed from the post-update
    // view; a push lands on the head only when it goes into the slot that
    // becomes the read slot.
    always_comb begin
        count_next  = count_reg + {2'b00, rx_push} - {2'b00, rx_pop};
        rd_ptr_next = rd_ptr_reg + {1'b0, rx_pop};
        head_next   = (rx_push && (wr_ptr_reg == rd_ptr_next)) ? pa_in : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rx_push) mem[wr_ptr_reg] <= pa_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            rx_state_reg <= RX_IDLE;
            stb_cnt_reg  <= 8'd0;
            ack_cnt_reg  <= 8'd0;
            pa_out_reg   <= 8'hff;
            stb_reg      <= 1'b0;
            ack_reg      <= 1'b0;
            tx_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            rx_state_reg <= rx_state_next;
            stb_cnt_reg  <= stb_cnt_next;
            ack_cnt_reg  <= ack_cnt_next;
            if (tx_load) pa_out_reg <= tx_data;
            // Strobes are decoded from the next state so they track the state exactly
            stb_reg      <= (tx_state_next == TX_STB);
            ack_reg      <= (rx_state_next == RX_ACK);
            tx_ready_reg <= (tx_state_next == TX_IDLE);
            busy_reg     <= (tx_state_next != TX_IDLE) || (rx_state_next != RX_IDLE);
            wr_ptr_reg   <= wr_ptr_reg + {1'b0, rx_push};
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rx_data_reg  <= head_next;
            rx_valid_reg <= (count_next != 3'd0);
        end
    end

    // Port C: ACK on bit 6, STB on bit 4, everything else passes pc_aux through
    for (genvar gi = 0; gi < 8; gi++) begin : g_pc
        if (gi == 6) begin : g_ack
            assign pc_out[gi] = ack_reg;
        end else if (gi == 4) begin : g_stb
            assign pc_out[gi] = stb_reg;
        end else begin : g_aux
            assign pc_out[gi] = pc_aux[gi];
        end
    end

    assign pa_out   = pa_out_reg;
    assign tx_ready = tx_ready_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = busy_reg;

    logic unused_pins;
    assign unused_pins = ^{pc_in[6], pc_in[4:0], pc_aux[6], pc_aux[4]};
endmodule
